ntt_stage_sequencer: RTL and testbench
======================================

Name: ntt_stage_sequencer

Overview:
- Sequences one 256-point Kyber NTT or INTT over the single-butterfly datapath (dual-port coefficient RAM, twiddle ROM, pipelined butterfly).
- Generates per-stage read addresses, the twiddle index, write addresses delayed to match the pipeline, and write enable.
- Inserts drain stalls between stages and provides a start/busy/done handshake to the wrapper's control path.

Parameters:
- LOGN, 8, log2 of the coefficient count (N = 256); the block supports only 8.
- RD_LAT, 1, RAM read latency in cycles.
- BF_LAT, 4, butterfly latency in cycles, operands in to results out.
- PIPE, RD_LAT+BF_LAT, delay from a read-address issue to the matching write (derived; do not override).

Ports:
- clk, in, 1, system clock.
- rst, in, 1, reset.
- start, in, 1, request a transform; sampled in IDLE only.
- mode, in, 1, transform select: 0 = NTT, 1 = INTT; latched at start.
- busy, out, 1, high from the start-accept cycle until done.
- done, out, 1, one-cycle pulse when the transform completes.
- mode_out, out, 1, latched mode, drives the butterfly CT/GS select.
- stage, out, 3, current stage 0..6.
- rd_addr_a, out, 8, RAM port A read address.
- rd_addr_b, out, 8, RAM port B read address.
- tw_addr, out, 8, twiddle ROM address.
- wr_addr_a, out, 8, RAM port A write address.
- wr_addr_b, out, 8, RAM port B write address.
- wen, out, 1, RAM write enable, both ports.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Clock port clk, reset port rst (asserted at 0).
- Reset state: all outputs 0, FSM in IDLE. A reset mid-transform aborts immediately, and no further wen pulses are produced.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: start=1 moves to RUN on the next cycle. Latch mode, set stage=0, i=0, busy=1.
  - RUN: issue butterfly i each cycle. When i=127, move to DRAIN.
  - DRAIN: count PIPE cycles. Then, if stage<6, increment stage, clear i and return to RUN; otherwise move to DONE.
  - DONE: done=1 and busy=0 for one cycle, then IDLE. A start asserted in DONE is ignored.
- start while busy is ignored. mode changes while busy have no effect.
- Address rules for stage s and butterfly i:
  - NTT: len = 128>>s, grp = i>>log2(len), off = i&(len-1), a = 2*len*grp+off, b = a+len, tw = (1<<s)+grp.
  - INTT: len = 2<<s, same a, b, grp; tw = (128>>s)-1-grp.
  - All address values fit in 8 bits. tw ranges 1..127, and bit 7 is always 0.
- Read outputs are registered and valid in the cycle the butterfly is issued (RUN cycles only). In all other states they hold 0.
- Write path:
  - wr_addr_a, wr_addr_b and wen are rd_addr_a, rd_addr_b and a RUN-issue flag, each delayed exactly PIPE cycles through a shift line.
  - wen is high exactly 128 cycles per stage.
  - The last write of a stage occurs in the final DRAIN cycle, so the next stage's first read sees committed data.
- Timing: start accepted at cycle 0. Stage s issues at cycles 1+133s .. 128+133s. The last wen is at cycle 931, and done is high at cycle 932.
- INTT final scaling by 1/128 (Montgomery factor) belongs to the butterfly/post-processing and is not performed here.

Decomposition:
- Shared package ntt_pkg:
  - constants N=256, NSTAGE=7, HALF=128;
  - state enum {IDLE, RUN, DRAIN, DONE};
  - PIPE derivation.
- Sub-module ntt_addr_calc: purely combinational (stage, i, mode) -> (a, b, tw). It is reused by the verification model.
- The delay line and FSM stay in ntt_stage_sequencer.

Test Plan:
- NTT start, mode=0: cycle 1 reads a=0, b=128, tw=1. Cycle 2 reads 1/129/1. The first wen is at cycle 6 with wr_addr 0/128. Stage 6 first issue is at cycle 799 with a=0, b=2, tw=64, then 1/3/64 and 4/6/65.
- INTT start, mode=1: stage 0 cycle 1 reads a=0, b=2, tw=127. Cycle 3 reads 4/6/126. Stage 6 first issue (cycle 799) reads 0/128/1.
- Full run checked against a reference model: every (a, b) pair covers 0..255 exactly once per stage. wen totals 896 pulses. done pulses once at cycle 932, and busy falls with it.
- start held high throughout: no second accept until IDLE; the next start is accepted at cycle 933. A mode toggle mid-run leaves mode_out unchanged.
- Drain gap: between stages wen is low for exactly PIPE=5 cycles before the next stage's writes (wen low cycles 134..138). The first read of the next stage follows the last write by exactly one cycle.
- rst=0 asserted at cycle 400: all outputs 0 asynchronously, and no wen after release. A fresh start then reproduces the cycle-1 values.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared constants, state type and pipeline-latency helper for the NTT stage sequencer.
package ntt_pkg;
    localparam int N      = 256;
    localparam int NSTAGE = 7;
    localparam int HALF   = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Read-issue to write-back distance: RAM read plus butterfly latency.
    function automatic int pipe_lat(input int rd_lat, input int bf_lat);
        return rd_lat + bf_lat;
    endfunction
endpackage

// File: rtl/ntt_addr_calc.sv
// Combinational butterfly addressing: (stage, butterfly index, mode) -> operand and twiddle addresses.
module ntt_addr_calc
    import ntt_pkg::*;
(
    input  logic [2:0]              stage,
    input  logic [6:0]              idx,
    input  logic                    mode,
    output logic [$clog2(N)-1:0]    a,
    output logic [$clog2(N)-1:0]    b,
    output logic [$clog2(N)-1:0]    tw
);
    localparam int AW = $clog2(N);

    logic [2:0]    len_log;
    logic [3:0]    grp_sh;
    logic [AW-1:0] len;
    logic [AW-1:0] idx_w;
    logic [AW-1:0] grp;
    logic [AW-1:0] off;

    // NTT halves the butterfly span each stage, INTT doubles it.
    always_comb begin
        len_log = mode ? (stage + 3'd1) : (3'd7 - stage);
        grp_sh  = {1'b0, len_log} + 4'd1;
        len     = AW'(1) << len_log;
        idx_w   = {{(AW-7){1'b0}}, idx};
        grp     = idx_w >> len_log;
        off     = idx_w & (len - AW'(1));
        a       = (grp << grp_sh) + off;
        b       = a + len;
        tw      = mode ? ((AW'(HALF) >> stage) - AW'(1) - grp)
                       : ((AW'(1) << stage) + grp);
    end
endmodule

// File: rtl/ntt_stage_sequencer.sv
// Stage/butterfly sequencer for a single-butterfly Kyber NTT/INTT with pipelined write-back.
//
// state | meaning
// IDLE  | waiting for start; read addresses held at 0
// RUN   | one butterfly issued per cycle, i = 0..127
// DRAIN | PIPE cycles for the pipeline to commit the stage's last write
// DONE  | one-cycle done pulse, start ignored
module ntt_stage_sequencer
    import ntt_pkg::*;
#(
    parameter int LOGN   = 8,
    parameter int RD_LAT = 1,
    parameter int BF_LAT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            mode,
    output logic            busy,
    output logic            done,
    output logic            mode_out,
    output logic [2:0]      stage,
    output logic [LOGN-1:0] rd_addr_a,
    output logic [LOGN-1:0] rd_addr_b,
    output logic [LOGN-1:0] tw_addr,
    output logic [LOGN-1:0] wr_addr_a,
    output logic [LOGN-1:0] wr_addr_b,
    output logic            wen
);
    localparam int PIPE = pipe_lat(RD_LAT, BF_LAT);
    localparam int IW   = $clog2(HALF);
    localparam int DW   = $clog2(PIPE + 1);

    state_e          state_q, state_d;
    logic [IW-1:0]   i_q, i_d;
    logic [2:0]      stage_q, stage_d;
    logic [DW-1:0]   drain_q, drain_d;
    logic            mode_q, mode_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [LOGN-1:0] rd_a_q, rd_a_d;
    logic [LOGN-1:0] rd_b_q, rd_b_d;
    logic [LOGN-1:0] tw_q, tw_d;
    logic [LOGN-1:0] calc_a, calc_b, calc_tw;
    logic            issue_now;

    logic [PIPE-1:0][LOGN-1:0] wa_pipe_q, wa_pipe_d;
    logic [PIPE-1:0][LOGN-1:0] wb_pipe_q, wb_pipe_d;
    logic [PIPE-1:0]           wen_pipe_q, wen_pipe_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        stage_d = stage_q;
        drain_d = drain_q;
        mode_d  = mode_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    mode_d  = mode;
                    stage_d = '0;
                    i_d     = '0;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                if (i_q == IW'(HALF - 1)) begin
                    state_d = DRAIN;
                    drain_d = DW'(PIPE - 1);
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            DRAIN: begin
                if (drain_q == '0) begin
                    if (stage_q == 3'(NSTAGE - 1)) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                        stage_d = stage_q + 1'b1;
                        i_d     = '0;
                    end
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Addresses are computed from the next-cycle indices so the registered
    // read outputs line up with the cycle the butterfly is issued.
    ntt_addr_calc u_addr_calc (
        .stage (stage_d),
        .idx   (i_d),
        .mode  (mode_d),
        .a     (calc_a),
        .b     (calc_b),
        .tw    (calc_tw)
    );

    assign issue_now = (state_q == RUN);

    always_comb begin
        rd_a_d     = (state_d == RUN) ? calc_a  : '0;
        rd_b_d     = (state_d == RUN) ? calc_b  : '0;
        tw_d       = (state_d == RUN) ? calc_tw : '0;
        wa_pipe_d  = {wa_pipe_q[PIPE-2:0], rd_a_q};
        wb_pipe_d  = {wb_pipe_q[PIPE-2:0], rd_b_q};
        wen_pipe_d = {wen_pipe_q[PIPE-2:0], issue_now};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_q        <= '0;
            stage_q    <= '0;
            drain_q    <= '0;
            mode_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_a_q     <= '0;
            rd_b_q     <= '0;
            tw_q       <= '0;
            wa_pipe_q  <= '0;
            wb_pipe_q  <= '0;
            wen_pipe_q <= '0;
        end else begin
            i_q        <= i_d;
            stage_q    <= stage_d;
            drain_q    <= drain_d;
            mode_q     <= mode_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_a_q     <= rd_a_d;
            rd_b_q     <= rd_b_d;
            tw_q       <= tw_d;
            wa_pipe_q  <= wa_pipe_d;
            wb_pipe_q  <= wb_pipe_d;
            wen_pipe_q <= wen_pipe_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign mode_out  = mode_q;
    assign stage     = stage_q;
    assign rd_addr_a = rd_a_q;
    assign rd_addr_b = rd_b_q;
    assign tw_addr   = tw_q;
    assign wr_addr_a = wa_pipe_q[PIPE-1];
    assign wr_addr_b = wb_pipe_q[PIPE-1];
    assign wen       = wen_pipe_q[PIPE-1];
endmodule

// File: tb/tb_ntt_stage_sequencer.sv
// Self-checking bench for ntt_stage_sequencer against a cycle-level reference of the transform schedule.
module tb_ntt_stage_sequencer;
    localparam int NREC = 940;
    localparam int PER  = 133;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       mode = 1'b0;
    logic       busy, done, mode_out, wen;
    logic [2:0] stage;
    logic [7:0] rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b;

    int vectors = 0;
    int miscompares = 0;

    logic       r_busy [NREC];
    logic       r_done [NREC];
    logic       r_mode [NREC];
    logic       r_wen  [NREC];
    logic [2:0] r_stage[NREC];
    logic [7:0] r_ra   [NREC];
    logic [7:0] r_rb   [NREC];
    logic [7:0] r_tw   [NREC];
    logic [7:0] r_wa   [NREC];
    logic [7:0] r_wb   [NREC];

    ntt_stage_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .busy      (busy),
        .done      (done),
        .mode_out  (mode_out),
        .stage     (stage),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .tw_addr   (tw_addr),
        .wr_addr_a (wr_addr_a),
        .wr_addr_b (wr_addr_b),
        .wen       (wen)
    );

    always #5 clk = ~clk;

    // Butterfly addressing straight from the transform definition.
    function automatic void ref_bf(input int s, input int i, input bit m,
                                   output int a, output int b, output int t);
        int len, grp, off;
        len = m ? (2 << s) : (128 >> s);
        grp = i / len;
        off = i % len;
        a   = 2 * len * grp + off;
        b   = a + len;
        t   = m ? ((128 >> s) - 1 - grp) : ((1 << s) + grp);
    endfunction

    task automatic do_reset();
        start = 1'b0;
        rst   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Accepts a start at cycle 0 and records outputs mid-cycle for cycles 1..ncyc.
    task automatic run_record(input bit m, input bit hold, input bit noise, input int ncyc);
        @(negedge clk);
        mode  = m;
        start = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            r_busy[c]  = busy;
            r_done[c]  = done;
            r_mode[c]  = mode_out;
            r_wen[c]   = wen;
            r_stage[c] = stage;
            r_ra[c]    = rd_addr_a;
            r_rb[c]    = rd_addr_b;
            r_tw[c]    = tw_addr;
            r_wa[c]    = wr_addr_a;
            r_wb[c]    = wr_addr_b;
            if (hold)
                start = 1'b1;
            else if (noise && c <= 932)
                start = 1'($urandom_range(0, 1));
            else
                start = 1'b0;
            if (noise)
                mode = 1'($urandom_range(0, 1));
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if ({busy, done, mode_out, stage, rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b, wen} !== 47'd0) begin
            miscompares++;
            $display("FAIL reset_outputs got %h expected 0",
                     {busy, done, mode_out, stage, rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b, wen});
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ntt_vectors();
        int tc[5];
        logic [23:0] te[5];
        tc = '{1, 2, 799, 800, 801};
        te = '{{8'd0, 8'd128, 8'd1}, {8'd1, 8'd129, 8'd1}, {8'd0, 8'd2, 8'd64},
               {8'd1, 8'd3, 8'd64}, {8'd4, 8'd6, 8'd65}};
        do_reset();
        run_record(1'b0, 1'b0, 1'b0, 933);
        for (int k = 0; k < 5; k++) begin
            vectors++;
            if ({r_ra[tc[k]], r_rb[tc[k]], r_tw[tc[k]]} !== te[k]) begin
                miscompares++;
                $display("FAIL ntt_read_c%0d got a/b/tw %0d/%0d/%0d expected %h",
                         tc[k], r_ra[tc[k]], r_rb[tc[k]], r_tw[tc[k]], te[k]);
            end
        end
        vectors++;
        if ({r_wen[5], r_wen[6], r_wa[6], r_wb[6]} !== {1'b0, 1'b1, 8'd0, 8'd128}) begin
            miscompares++;
            $display("FAIL ntt_first_write wen5=%b wen6=%b wr=%0d/%0d expected 0,1,0/128",
                     r_wen[5], r_wen[6], r_wa[6], r_wb[6]);
        end
    endtask

    task automatic test_intt_vectors();
        int tc[3];
        logic [23:0] te[3];
        tc = '{1, 3, 799};
        te = '{{8'd0, 8'd2, 8'd127}, {8'd4, 8'd6, 8'd126}, {8'd0, 8'd128, 8'd1}};
        do_reset();
        run_record(1'b1, 1'b0, 1'b0, 933);
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if ({r_ra[tc[k]], r_rb[tc[k]], r_tw[tc[k]]} !== te[k]) begin
                miscompares++;
                $display("FAIL intt_read_c%0d got a/b/tw %0d/%0d/%0d expected %h",
                         tc[k], r_ra[tc[k]], r_rb[tc[k]], r_tw[tc[k]], te[k]);
            end
        end
    endtask

    // Random mode, random start/mode noise while busy; every cycle checked against the schedule.
    task automatic test_random_model();
        for (int run = 0; run < 3; run++) begin
            bit m;
            int bad, wen_total;
            int cov[256];
            m = 1'($urandom_range(0, 1));
            do_reset();
            run_record(m, 1'b0, 1'b1, 933);
            wen_total = 0;
            for (int c = 1; c <= 933; c++) begin
                int s, ea, eb, et, wa, wb, wt;
                bit iss, wiss;
                logic [46:0] ev, ov;
                s    = (c - 1) / PER;
                iss  = (c <= 931) && (((c - 1) % PER) < 128);
                wiss = (c >= 6) && (c - 5 <= 931) && (((c - 6) % PER) < 128);
                ea = 0; eb = 0; et = 0; wa = 0; wb = 0;
                if (iss) ref_bf(s, (c - 1) % PER, m, ea, eb, et);
                if (wiss) ref_bf((c - 6) / PER, (c - 6) % PER, m, wa, wb, wt);
                ev = {(c <= 931), (c == 932), m, (c <= 931) ? 3'(s) : 3'd0,
                      8'(ea), 8'(eb), 8'(et), 8'(wa), 8'(wb), wiss};
                ov = {r_busy[c], r_done[c], r_mode[c], (c <= 931) ? r_stage[c] : 3'd0,
                      r_ra[c], r_rb[c], r_tw[c], r_wa[c], r_wb[c], r_wen[c]};
                if (r_wen[c] === 1'b1) wen_total++;
                vectors++;
                if (ov !== ev) begin
                    miscompares++;
                    $display("FAIL model_m%0d_c%0d got %h expected %h", m, c, ov, ev);
                end
            end
            vectors++;
            if (wen_total != 896) begin
                miscompares++;
                $display("FAIL wen_total_m%0d got %0d expected 896", m, wen_total);
            end
            for (int s = 0; s < 7; s++) begin
                for (int k = 0; k < 256; k++) cov[k] = 0;
                for (int i = 0; i < 128; i++) begin
                    cov[r_ra[1 + PER * s + i]]++;
                    cov[r_rb[1 + PER * s + i]]++;
                end
                bad = 0;
                for (int k = 0; k < 256; k++) if (cov[k] != 1) bad++;
                vectors++;
                if (bad != 0) begin
                    miscompares++;
                    $display("FAIL coverage_m%0d_s%0d got %0d addresses not hit once expected 0", m, s, bad);
                end
            end
        end
    endtask

    task automatic test_drain_gap();
        do_reset();
        run_record(1'($urandom_range(0, 1)), 1'b0, 1'b0, 933);
        for (int k = 1; k < 7; k++) begin
            int low;
            low = 0;
            for (int c = PER * k + 1; c <= PER * k + 5; c++) if (r_wen[c] === 1'b0) low++;
            vectors++;
            if ({3'(low), r_wen[PER * k], r_wen[PER * k + 6], r_stage[PER * k + 1]} !== {3'd5, 1'b1, 1'b1, 3'(k)}) begin
                miscompares++;
                $display("FAIL drain_gap_%0d got low=%0d last=%b next=%b stage=%0d expected 5,1,1,%0d",
                         k, low, r_wen[PER * k], r_wen[PER * k + 6], r_stage[PER * k + 1], k);
            end
        end
    endtask

    task automatic test_start_hold();
        bit m;
        int busy_cnt, ea, eb, et;
        m = 1'($urandom_range(0, 1));
        do_reset();
        run_record(m, 1'b1, 1'b0, 935);
        busy_cnt = 0;
        for (int c = 1; c <= 931; c++) if (r_busy[c] === 1'b1) busy_cnt++;
        vectors++;
        if (busy_cnt != 931) begin
            miscompares++;
            $display("FAIL hold_busy got %0d busy cycles expected 931", busy_cnt);
        end
        vectors++;
        if ({r_busy[932], r_done[932], r_busy[933], r_done[933], r_ra[933], r_rb[933]} !== {1'b0, 1'b1, 1'b0, 1'b0, 16'd0}) begin
            miscompares++;
            $display("FAIL hold_no_reaccept got busy/done %b%b %b%b rd %0d/%0d expected 01 00 0/0",
                     r_busy[932], r_done[932], r_busy[933], r_done[933], r_ra[933], r_rb[933]);
        end
        ref_bf(0, 0, m, ea, eb, et);
        vectors++;
        if ({r_busy[934], r_ra[934], r_rb[934], r_tw[934]} !== {1'b1, 8'(ea), 8'(eb), 8'(et)}) begin
            miscompares++;
            $display("FAIL hold_reaccept_933 got busy=%b rd %0d/%0d/%0d expected 1 %0d/%0d/%0d",
                     r_busy[934], r_ra[934], r_rb[934], r_tw[934], ea, eb, et);
        end
    endtask

    task automatic test_reset_abort();
        bit m, m2;
        int wen_seen, busy_seen, ea, eb, et;
        m  = 1'($urandom_range(0, 1));
        m2 = 1'($urandom_range(0, 1));
        do_reset();
        run_record(m, 1'b0, 1'b0, 400);
        vectors++;
        if (r_busy[400] !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_busy_before got %b expected 1", r_busy[400]);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if ({busy, done, mode_out, stage, rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b, wen} !== 47'd0) begin
            miscompares++;
            $display("FAIL abort_async_clear got %h expected 0",
                     {busy, done, mode_out, stage, rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b, wen});
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        wen_seen = 0;
        busy_seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (wen !== 1'b0) wen_seen++;
            if (busy !== 1'b0) busy_seen++;
        end
        vectors++;
        if (wen_seen + busy_seen != 0) begin
            miscompares++;
            $display("FAIL abort_quiet got wen=%0d busy=%0d cycles expected 0/0", wen_seen, busy_seen);
        end
        run_record(m2, 1'b0, 1'b0, 10);
        ref_bf(0, 0, m2, ea, eb, et);
        vectors++;
        if ({r_ra[1], r_rb[1], r_tw[1], r_wen[6], r_wa[6], r_wb[6]} !== {8'(ea), 8'(eb), 8'(et), 1'b1, 8'(ea), 8'(eb)}) begin
            miscompares++;
            $display("FAIL abort_restart got %0d/%0d/%0d wen=%b wr %0d/%0d expected %0d/%0d/%0d 1 %0d/%0d",
                     r_ra[1], r_rb[1], r_tw[1], r_wen[6], r_wa[6], r_wb[6], ea, eb, et, ea, eb);
        end
    endtask

    initial begin
        test_reset();
        test_ntt_vectors();
        test_intt_vectors();
        test_random_model();
        test_drain_gap();
        test_start_hold();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
